mux_nx1_pipe: RTL and testbench

- Parametrised successor of the 2:1 combinational selector: M-way, N-bit operand select followed by a registered pipeline stage.
- Valid/ready handshake at both ends; 2-entry skid buffer so in_ready is a pure register output.
- Synchronous flush for branch/exception squash.
- Sits at stage boundaries of the pipelined RISC-V core, e.g. ID/EX operand forwarding select.

---
 rtl/mux_nx1_pipe_pkg.sv | 18 +
 rtl/mux_nx1_pipe_if.sv | 31 +++
 rtl/mux_nx1_pipe_mux_nx1.sv | 32 +++
 rtl/mux_nx1_pipe.sv | 107 ++++++++++
 tb/tb_mux_nx1_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_nx1_pipe_pkg.sv
// Shared types for the registered operand-select stage and its helpers.
// Holds the buffer state encoding and the default datapath width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    localparam int DATA_W_DEFAULT = 32;

    // Select width for an M-way choice; never narrower than one bit.
    function automatic int sel_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1_pipe_if.sv
// Handshake bundle for the select stage: upstream beat, flush and downstream beat.
// master is the surrounding pipeline, slave is the select stage itself.
interface mux_nx1_pipe_if #(
    parameter int N = pipe_pkg::DATA_W_DEFAULT,
    parameter int M = 4
);
    import pipe_pkg::*;

    localparam int SEL_W = sel_width(M);

    logic [M*N-1:0]   in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;

    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

endinterface

// File: rtl/mux_nx1_pipe_mux_nx1.sv
// Combinational M-way, N-bit word select with an out-of-range flag.
// An out-of-range select yields an all-zero word rather than an arbitrary input.
module mux_nx1
    import pipe_pkg::*;
#(
    parameter int N = DATA_W_DEFAULT,
    parameter int M = 4,
    localparam int SEL_W = sel_width(M)
) (
    input  logic [M*N-1:0]   data,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     y,
    output logic             oor
);

    logic [N-1:0] masked [M];

    // AND-OR tree: at most one lane is non-zero, none when sel is out of range.
    for (genvar gi = 0; gi < M; gi++) begin : g_lane
        assign masked[gi] = (sel == SEL_W'(gi)) ? data[gi*N +: N] : '0;
    end

    always_comb begin
        y = '0;
        for (int k = 0; k < M; k++) begin
            y = y | masked[k];
        end
    end

    assign oor = ({1'b0, sel} >= (SEL_W + 1)'(M));

endmodule

// File: rtl/mux_nx1_pipe.sv
// Registered M:1 operand select with valid/ready on both sides and a 2-entry skid buffer.
// in_ready is a flop so upstream never sees a combinational path from out_ready.
module mux_nx1_pipe
    import pipe_pkg::*;
#(
    parameter int N = DATA_W_DEFAULT,
    parameter int M = 4,
    localparam int SEL_W = sel_width(M)
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_nx1_pipe_if.slave bus
);

    state_t           state_reg;
    logic [N-1:0]     main_data_reg;
    logic             main_err_reg;
    logic [N-1:0]     skid_data_reg;
    logic             skid_err_reg;
    logic             in_ready_reg;

    logic [SEL_W-1:0] sel;
    logic [N-1:0]     cap_data;
    logic             cap_err;
    logic             accept;
    logic             pop;
    logic             out_valid;

    assign sel = bus.in_sel;

    mux_nx1 #(
        .N(N),
        .M(M)
    ) u_mux (
        .data(bus.in_data),
        .sel (sel),
        .y   (cap_data),
        .oor (cap_err)
    );

    assign out_valid = (state_reg != EMPTY);
    assign accept    = bus.in_valid & in_ready_reg;
    assign pop       = out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else if (bus.flush) begin
            // Squash wins over any same-cycle accept or pop.
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg     <= ONE;
                        main_data_reg <= cap_data;
                        main_err_reg  <= cap_err;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_reg <= cap_data;
                        main_err_reg  <= cap_err;
                    end else if (accept) begin
                        state_reg     <= TWO;
                        skid_data_reg <= cap_data;
                        skid_err_reg  <= cap_err;
                        in_ready_reg  <= 1'b0;
                    end else if (pop) begin
                        state_reg <= EMPTY;
                    end
                end
                TWO: begin
                    // Skid drains into main and is zeroed so no stale word lingers.
                    if (pop) begin
                        state_reg     <= ONE;
                        main_data_reg <= skid_data_reg;
                        main_err_reg  <= skid_err_reg;
                        skid_data_reg <= '0;
                        skid_err_reg  <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= EMPTY;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data_reg;
    assign bus.sel_err   = main_err_reg;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe: an M=4 and an M=3 instance run the same stimulus.
// A negedge monitor models the stage as a bounded FIFO of selected words.
`timescale 1ns/1ps
module tb_mux_nx1_pipe;

    logic clk;
    logic rst_n;

    mux_nx1_pipe_if #(.N(32), .M(4)) bus4 ();
    mux_nx1_pipe_if #(.N(32), .M(3)) bus3 ();

    mux_nx1_pipe #(.N(32), .M(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux_nx1_pipe #(.N(32), .M(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q [2][$];
    bit   zeroed [2];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp_v, $time);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            zeroed[i] = 1'b1;
        end
    endtask

    // Reference: the stage is a FIFO of depth 2 holding the selected word (or 0 + error).
    task automatic mon(input int id, input int m, input logic ov, input logic [31:0] od,
                       input logic se, input logic ir, input logic iv,
                       input logic [127:0] idat, input logic [1:0] isel,
                       input logic ordy, input logic fl);
        int   sz;
        exp_t e;
        sz = q[id].size();
        chk($sformatf("out_valid_m%0d", m), 32'(ov), 32'(sz > 0));
        chk($sformatf("in_ready_m%0d", m), 32'(ir), 32'(sz < 2));
        if (sz > 0) begin
            chk($sformatf("out_data_m%0d", m), od, q[id][0].data);
            chk($sformatf("sel_err_m%0d", m), 32'(se), 32'(q[id][0].err));
        end else if (zeroed[id]) begin
            chk($sformatf("idle_data_m%0d", m), od, 32'h0);
            chk($sformatf("idle_err_m%0d", m), 32'(se), 32'h0);
        end
        if (fl) begin
            q[id].delete();
            zeroed[id] = 1'b1;
        end else begin
            if (ov && ordy && sz > 0) void'(q[id].pop_front());
            if (iv && sz < 2) begin
                e.err  = (int'(isel) >= m);
                e.data = e.err ? 32'h0 : 32'(idat >> (int'(isel) * 32));
                q[id].push_back(e);
                zeroed[id] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            clear_model();
        end else begin
            mon(0, 4, bus4.out_valid, bus4.out_data, bus4.sel_err, bus4.in_ready,
                bus4.in_valid, bus4.in_data, bus4.in_sel, bus4.out_ready, bus4.flush);
            mon(1, 3, bus3.out_valid, bus3.out_data, bus3.sel_err, bus3.in_ready,
                bus3.in_valid, {32'h0, bus3.in_data}, bus3.in_sel, bus3.out_ready, bus3.flush);
        end
    end

    task automatic drive(input logic v, input logic [127:0] d, input logic [1:0] s,
                         input logic ordy, input logic fl);
        bus4.in_valid = v;  bus3.in_valid = v;
        bus4.in_data  = d;  bus3.in_data  = d[95:0];
        bus4.in_sel   = s;  bus3.in_sel   = s;
        bus4.out_ready = ordy; bus3.out_ready = ordy;
        bus4.flush    = fl; bus3.flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] fixed_data;
    logic         cur_ordy;

    // Offer one beat and hold it until the stage takes it (bounded wait).
    task automatic offer(input logic [1:0] s);
        int n;
        n = 0;
        drive(1'b1, fixed_data, s, cur_ordy, 1'b0);
        forever begin
            @(negedge clk);
            if (bus4.in_ready) break;
            n++;
            if (n > 50) begin
                n_checks++;
                $display("FAIL offer_timeout: got in_ready 0 required 1 within 50 cycles");
                break;
            end
        end
        step();
        drive(1'b0, fixed_data, s, cur_ordy, 1'b0);
    endtask

    initial begin
        fixed_data = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
        cur_ordy   = 1'b1;
        rst_n      = 1'b0;
        clear_model();
        drive(1'b0, '0, 2'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(bus4.out_valid), 32'h0);
        chk("reset_out_data", bus4.out_data, 32'h0);
        chk("reset_in_ready", 32'(bus4.in_ready), 32'h1);
        chk("reset_sel_err", 32'(bus3.sel_err), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Basic single beat, then streaming, then out-of-range followed by in-range.
        offer(2'd2);
        repeat (2) step();
        for (int i = 0; i < 4; i++) offer(2'(i));
        offer(2'd3);
        offer(2'd1);
        repeat (3) step();

        // Back-pressure: two beats fill the buffer, the third is held off.
        cur_ordy = 1'b0;
        drive(1'b0, fixed_data, 2'd0, 1'b0, 1'b0);
        offer(2'd0);
        offer(2'd1);
        drive(1'b1, fixed_data, 2'd2, 1'b0, 1'b0);
        repeat (3) step();
        chk("bp_in_ready_low", 32'(bus4.in_ready), 32'h0);
        chk("bp_head_stable", bus4.out_data, 32'h0000AAAA);
        cur_ordy = 1'b1;
        offer(2'd2);
        repeat (4) step();

        // Flush while full, with a same-cycle offer and pop.
        cur_ordy = 1'b0;
        drive(1'b0, fixed_data, 2'd0, 1'b0, 1'b0);
        offer(2'd0);
        offer(2'd1);
        drive(1'b1, fixed_data, 2'd2, 1'b1, 1'b1);
        step();
        drive(1'b0, fixed_data, 2'd2, 1'b1, 1'b0);
        repeat (3) step();

        // Asynchronous reset between clock edges while one beat is held.
        cur_ordy = 1'b0;
        drive(1'b0, fixed_data, 2'd0, 1'b0, 1'b0);
        offer(2'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus4.out_valid), 32'h0);
        chk("async_out_data", bus4.out_data, 32'h0);
        chk("async_in_ready", 32'(bus4.in_ready), 32'h1);
        chk("async_sel_err_m3", 32'(bus3.sel_err), 32'h0);
        clear_model();
        rst_n = 1'b1;
        cur_ordy = 1'b1;
        step();
        offer(2'd1);
        repeat (3) step();

        // Randomised traffic against the FIFO model.
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)),
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 24) == 0));
            step();
        end

        drive(1'b0, '0, 2'd0, 1'b1, 1'b0);
        repeat (5) step();
        chk("drain_m4", 32'(q[0].size()), 32'h0);
        chk("drain_m3", 32'(q[1].size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
